// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the register file / scoreboard slice: default
// geometry, the register-address type and the ALU opcode encoding.
package regfile_sb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NREGS_DEF  = 8;
  localparam int ADDR_W_DEF = $clog2(NREGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLL = 4'h5,
    ALU_SRL = 4'h6,
    ALU_SRA = 4'h7,
    ALU_SLT = 4'h8
  } alu_op_e;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: register mux with write-first bypass and an
// optional hardwired-zero register 0.
module regfile_sb_rdport
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter bit ZERO_REG = 1'b0
) (
  input  logic [NREGS*DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  output logic [DATA_W-1:0]       rd_data_o
);

  // Zero register wins over bypass so a dropped r0 write never leaks through.
  always_comb begin
    rd_data_o = regs_i[rd_addr_i*DATA_W +: DATA_W];
    if (ZERO_REG && (rd_addr_i == '0)) begin
      rd_data_o = '0;
    end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_o = wr_data_i;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-read register file with write-first bypass and a
// per-register pending-write scoreboard that produces the decode stall.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NRD-1:0]        rd_en_i,
  input  logic [NRD*ADDR_W-1:0] rd_addr_i,
  output logic [NRD*DATA_W-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  iss_en_i,
  input  logic [ADDR_W-1:0]     iss_addr_i,
  output logic                  iss_ready_o,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [NREGS-1:0]      pend_vec_o,
  output logic [ADDR_W:0]       pend_cnt_o
);

  logic [NREGS*DATA_W-1:0] regs_q, regs_d;
  logic [NREGS-1:0]        pend_q, pend_d;
  logic [ADDR_W:0]         cnt_q, cnt_d;
  logic                    wr_eff;
  logic                    iss_hit;

  assign wr_eff = wr_en_i && !(ZERO_REG && (wr_addr_i == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr_eff) begin
      regs_d[wr_addr_i*DATA_W +: DATA_W] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_sb_rdport #(
      .DATA_W  (DATA_W),
      .NREGS   (NREGS),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rdport (
      .regs_i   (regs_q),
      .rd_addr_i(rd_addr_i[i*ADDR_W +: ADDR_W]),
      .wr_en_i  (wr_eff),
      .wr_addr_i(wr_addr_i),
      .wr_data_i(wr_data_i),
      .rd_data_o(rd_data_o[i*DATA_W +: DATA_W])
    );
  end

  // A pending destination may be reissued in the cycle its writeback lands.
  always_comb begin
    iss_ready_o = !pend_q[iss_addr_i] || (wr_en_i && (wr_addr_i == iss_addr_i));
    if (ZERO_REG && (iss_addr_i == '0)) begin
      iss_ready_o = 1'b1;
    end
  end

  assign iss_hit = iss_en_i && iss_ready_o && !(ZERO_REG && (iss_addr_i == '0));

  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < NREGS; r++) begin
      if (flush_i) begin
        pend_d[r] = iss_hit && (iss_addr_i == ADDR_W'(r));
      end else if (iss_hit && (iss_addr_i == ADDR_W'(r))) begin
        pend_d[r] = 1'b1;
      end else if (wr_en_i && (wr_addr_i == ADDR_W'(r))) begin
        pend_d[r] = 1'b0;
      end
    end
  end

  // Count is recomputed from the next pending vector, never accumulated.
  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[r]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    stall_o = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_en_i[i] && pend_q[rd_addr_i[i*ADDR_W +: ADDR_W]] &&
          !(wr_en_i && (wr_addr_i == rd_addr_i[i*ADDR_W +: ADDR_W]))) begin
        stall_o = 1'b1;
      end
    end
  end

  assign pend_vec_o = pend_q;
  assign pend_cnt_o = cnt_q;

  iss_when_ready_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(iss_en_i && !iss_ready_o));

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a default build and a ZERO_REG=1 build share
// clock and reset; all comparisons go through checkOutput.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        iss_en;
  logic [2:0]  iss_addr;
  logic        iss_ready;
  logic        flush;
  logic        stall;
  logic [7:0]  pend_vec;
  logic [3:0]  pend_cnt;

  logic [1:0]  z_rd_en;
  logic [5:0]  z_rd_addr;
  logic [31:0] z_rd_data;
  logic        z_wr_en;
  logic [2:0]  z_wr_addr;
  logic [15:0] z_wr_data;
  logic        z_iss_en;
  logic [2:0]  z_iss_addr;
  logic        z_iss_ready;
  logic        z_stall;
  logic [7:0]  z_pend_vec;
  logic [3:0]  z_pend_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .iss_ready_o(iss_ready), .flush_i(flush), .stall_o(stall),
    .pend_vec_o(pend_vec), .pend_cnt_o(pend_cnt)
  );

  regfile_sb #(.ZERO_REG(1'b1)) dut_zero (
    .clk_i(clk), .rst_i(rst), .rd_en_i(z_rd_en), .rd_addr_i(z_rd_addr),
    .rd_data_o(z_rd_data), .wr_en_i(z_wr_en), .wr_addr_i(z_wr_addr),
    .wr_data_i(z_wr_data), .iss_en_i(z_iss_en), .iss_addr_i(z_iss_addr),
    .iss_ready_o(z_iss_ready), .flush_i(1'b0), .stall_o(z_stall),
    .pend_vec_o(z_pend_vec), .pend_cnt_o(z_pend_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] wa,
                               input logic [15:0] wd, input logic ie,
                               input logic [2:0] ia, input logic fl);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; flush = fl;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rd_en = '0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    iss_en = 0; iss_addr = '0; flush = 0;
    z_rd_en = '0; z_rd_addr = '0; z_wr_en = 0; z_wr_addr = '0; z_wr_data = '0;
    z_iss_en = 0; z_iss_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    rd_en = 2'b11;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      rd_addr = {3'(r), 3'(r)};
      #1;
      checkOutput($sformatf("reset_rd0_r%0d", r), {16'h0, rd_data[15:0]}, 32'h0);
      checkOutput($sformatf("reset_rd1_r%0d", r), {16'h0, rd_data[31:16]}, 32'h0);
    end
    checkOutput("reset_pend_vec", {24'h0, pend_vec}, 32'h0);
    checkOutput("reset_pend_cnt", {28'h0, pend_cnt}, 32'h0);
    checkOutput("reset_stall", {31'h0, stall}, 32'h0);
    rd_en = 2'b00;

    // Bypass then registered value.
    rd_addr = {3'd0, 3'd3};
    applyStimulus(1, 3'd3, 16'hBEEF, 0, 3'd0, 0);
    checkOutput("bypass_same_cycle", {16'h0, rd_data[15:0]}, 32'hBEEF);
    applyStimulus(0, 3'd0, 16'h0, 0, 3'd0, 0);
    checkOutput("bypass_registered", {16'h0, rd_data[15:0]}, 32'hBEEF);

    // Load interlock on r5.
    applyStimulus(0, 3'd0, 16'h0, 1, 3'd5, 0);
    checkOutput("load_iss_ready", {31'h0, iss_ready}, 32'h1);
    rd_en = 2'b10; rd_addr = {3'd5, 3'd0};
    applyStimulus(0, 3'd0, 16'h0, 0, 3'd0, 0);
    checkOutput("load_stall", {31'h0, stall}, 32'h1);
    checkOutput("load_pend_cnt", {28'h0, pend_cnt}, 32'h1);
    checkOutput("load_pend_vec", {24'h0, pend_vec}, 32'h20);
    rd_en = 2'b01;
    #1 checkOutput("load_no_stall_disabled_port", {31'h0, stall}, 32'h0);
    rd_en = 2'b10;
    applyStimulus(1, 3'd5, 16'h0042, 0, 3'd0, 0);
    checkOutput("load_wb_stall", {31'h0, stall}, 32'h0);
    checkOutput("load_wb_rd1", {16'h0, rd_data[31:16]}, 32'h0042);
    applyStimulus(0, 3'd0, 16'h0, 0, 3'd0, 0);
    checkOutput("load_cleared", {24'h0, pend_vec}, 32'h0);
    checkOutput("load_rd1_reg", {16'h0, rd_data[31:16]}, 32'h0042);
    rd_en = 2'b00;

    // Same-cycle issue and write to r2.
    applyStimulus(0, 3'd0, 16'h0, 1, 3'd2, 0);
    applyStimulus(0, 3'd0, 16'h0, 0, 3'd2, 0);
    checkOutput("sc_not_ready", {31'h0, iss_ready}, 32'h0);
    applyStimulus(1, 3'd2, 16'h1234, 1, 3'd2, 0);
    checkOutput("sc_iss_ready", {31'h0, iss_ready}, 32'h1);
    rd_addr = {3'd0, 3'd2};
    applyStimulus(0, 3'd0, 16'h0, 0, 3'd0, 0);
    checkOutput("sc_pend_vec", {24'h0, pend_vec}, 32'h04);
    checkOutput("sc_reg2", {16'h0, rd_data[15:0]}, 32'h1234);
    applyStimulus(1, 3'd2, 16'h5678, 0, 3'd0, 0);
    applyStimulus(0, 3'd0, 16'h0, 0, 3'd0, 0);
    checkOutput("sc_cleared", {24'h0, pend_vec}, 32'h0);

    // Flush keeps only the same-cycle issue.
    applyStimulus(0, 3'd0, 16'h0, 1, 3'd1, 0);
    applyStimulus(0, 3'd0, 16'h0, 1, 3'd4, 0);
    applyStimulus(0, 3'd0, 16'h0, 1, 3'd6, 0);
    applyStimulus(0, 3'd0, 16'h0, 0, 3'd0, 0);
    checkOutput("flush_pre_vec", {24'h0, pend_vec}, 32'h52);
    checkOutput("flush_pre_cnt", {28'h0, pend_cnt}, 32'h3);
    applyStimulus(0, 3'd0, 16'h0, 1, 3'd7, 1);
    applyStimulus(0, 3'd0, 16'h0, 0, 3'd0, 0);
    checkOutput("flush_vec", {24'h0, pend_vec}, 32'h80);
    checkOutput("flush_cnt", {28'h0, pend_cnt}, 32'h1);
    rd_en = 2'b01; rd_addr = {3'd0, 3'd7};
    #1 checkOutput("flush_stall_r7", {31'h0, stall}, 32'h1);
    rd_en = 2'b00;

    // Zero-register build.
    @(negedge clk);
    z_wr_en = 1; z_wr_addr = 3'd0; z_wr_data = 16'hFFFF;
    z_iss_en = 1; z_iss_addr = 3'd0;
    z_rd_en = 2'b01; z_rd_addr = {3'd0, 3'd0};
    #1;
    checkOutput("zero_rd_bypass", {16'h0, z_rd_data[15:0]}, 32'h0);
    checkOutput("zero_stall", {31'h0, z_stall}, 32'h0);
    checkOutput("zero_iss_ready", {31'h0, z_iss_ready}, 32'h1);
    @(negedge clk);
    z_wr_en = 1; z_wr_addr = 3'd1; z_wr_data = 16'hA5A5; z_iss_en = 0;
    #1;
    checkOutput("zero_rd_reg", {16'h0, z_rd_data[15:0]}, 32'h0);
    checkOutput("zero_pend_vec", {24'h0, z_pend_vec}, 32'h0);
    checkOutput("zero_pend_cnt", {28'h0, z_pend_cnt}, 32'h0);
    @(negedge clk);
    z_wr_en = 0; z_rd_addr = {3'd0, 3'd1};
    #1 checkOutput("zero_r1_normal", {16'h0, z_rd_data[15:0]}, 32'hA5A5);

    // Reset beats a simultaneous write and issue.
    @(negedge clk);
    rst = 1; wr_en = 1; wr_addr = 3'd3; wr_data = 16'h1111;
    iss_en = 1; iss_addr = 3'd3;
    @(negedge clk);
    rst = 0; wr_en = 0; iss_en = 0; rd_addr = {3'd0, 3'd3};
    #1;
    checkOutput("rst_prio_vec", {24'h0, pend_vec}, 32'h0);
    checkOutput("rst_prio_cnt", {28'h0, pend_cnt}, 32'h0);
    checkOutput("rst_prio_r3", {16'h0, rd_data[15:0]}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
